// File: rtl/rgb_to_ycbcr_pkg.sv
// rtl/rgb_to_ycbcr_pkg.sv - BT.601 coefficients, offsets and packing modes for rgb_to_ycbcr
package rgb_to_ycbcr_pkg;

  localparam int PIPE_LAT = 3;

  // Q8 coefficients; each row sums to 256 so every result stays within 8 bits
  localparam logic [7:0] COEF_Y_R  = 8'd77;
  localparam logic [7:0] COEF_Y_G  = 8'd150;
  localparam logic [7:0] COEF_Y_B  = 8'd29;
  localparam logic [7:0] COEF_CB_R = 8'd43;
  localparam logic [7:0] COEF_CB_G = 8'd85;
  localparam logic [7:0] COEF_CB_B = 8'd128;
  localparam logic [7:0] COEF_CR_R = 8'd128;
  localparam logic [7:0] COEF_CR_G = 8'd107;
  localparam logic [7:0] COEF_CR_B = 8'd21;

  localparam logic [15:0] CHROMA_OFFSET = 16'd32768;

  localparam int OUT_MODE_GRAY  = 0;
  localparam int OUT_MODE_YCBCR = 1;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] k);
    return {8'd0, a} * {8'd0, k};
  endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - N-stage shift register for the frame sync bundle
module sync_delay #(
  parameter int N = 3,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[N-1];

endmodule

// File: rtl/rgb_to_ycbcr.sv
// rtl/rgb_to_ycbcr.sv - 3-stage RGB888 to BT.601 YCbCr converter with aligned frame sync
module rgb_to_ycbcr
  import rgb_to_ycbcr_pkg::*;
#(
  parameter int OUT_MODE = OUT_MODE_GRAY
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [23:0] pix_data_in,
  output logic [23:0] gray_data,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken
);

  logic [7:0] r, g, b;
  assign b = pix_data_in[23:16];
  assign g = pix_data_in[15:8];
  assign r = pix_data_in[7:0];

  logic [15:0] y_r_p, y_g_p, y_b_p;
  logic [15:0] cb_r_p, cb_g_p, cb_b_p;
  logic [15:0] cr_r_p, cr_g_p, cr_b_p;
  logic [15:0] y_sum, cb_sum, cr_sum;
  logic [7:0]  y_q, cb_q, cr_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      y_r_p  <= '0;
      y_g_p  <= '0;
      y_b_p  <= '0;
      cb_r_p <= '0;
      cb_g_p <= '0;
      cb_b_p <= '0;
      cr_r_p <= '0;
      cr_g_p <= '0;
      cr_b_p <= '0;
    end else begin
      y_r_p  <= mul8(r, COEF_Y_R);
      y_g_p  <= mul8(g, COEF_Y_G);
      y_b_p  <= mul8(b, COEF_Y_B);
      cb_r_p <= mul8(r, COEF_CB_R);
      cb_g_p <= mul8(g, COEF_CB_G);
      cb_b_p <= mul8(b, COEF_CB_B);
      cr_r_p <= mul8(r, COEF_CR_R);
      cr_g_p <= mul8(g, COEF_CR_G);
      cr_b_p <= mul8(b, COEF_CR_B);
    end
  end

  // Positive term plus offset first: it never exceeds 65408 and always covers
  // the two subtracted products, so 16-bit arithmetic neither wraps nor underflows.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      y_sum  <= '0;
      cb_sum <= '0;
      cr_sum <= '0;
    end else begin
      y_sum  <= y_r_p + y_g_p + y_b_p;
      cb_sum <= cb_b_p + CHROMA_OFFSET - cb_r_p - cb_g_p;
      cr_sum <= cr_r_p + CHROMA_OFFSET - cr_g_p - cr_b_p;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      y_q  <= '0;
      cb_q <= '0;
      cr_q <= '0;
    end else begin
      y_q  <= y_sum[15:8];
      cb_q <= cb_sum[15:8];
      cr_q <= cr_sum[15:8];
    end
  end

  logic unused_frac;
  assign unused_frac = ^{y_sum[7:0], cb_sum[7:0], cr_sum[7:0]};

  sync_t sync_in, sync_out;
  assign sync_in = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};

  sync_delay #(
    .N (PIPE_LAT),
    .W ($bits(sync_t))
  ) u_sync_delay (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .din   (sync_in),
    .dout  (sync_out)
  );

  assign post_frame_vsync = sync_out.vsync;
  assign post_frame_href  = sync_out.href;
  assign post_frame_clken = sync_out.clken;

  logic [23:0] packed_pix;
  generate
    if (OUT_MODE == OUT_MODE_YCBCR) begin : g_ycbcr
      assign packed_pix = {y_q, cb_q, cr_q};
    end else begin : g_gray
      assign packed_pix = {y_q, y_q, y_q};
    end
  endgenerate

  assign gray_data = (sync_out.href && sync_out.clken) ? packed_pix : 24'h000000;

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// tb/tb_rgb_to_ycbcr.sv - self-checking bench for rgb_to_ycbcr in both output modes
module tb_rgb_to_ycbcr;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [23:0] pix = 24'h0;
  logic [23:0] gray_g, gray_c;
  logic        pv_g, ph_g, pc_g, pv_c, ph_c, pc_c;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic        ce;
    logic [23:0] pix;
  } in_t;

  in_t hist[$];

  always #5 sys_clk = ~sys_clk;

  rgb_to_ycbcr #(.OUT_MODE(0)) dut_g (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
    .pix_data_in(pix), .gray_data(gray_g),
    .post_frame_vsync(pv_g), .post_frame_href(ph_g), .post_frame_clken(pc_g)
  );

  rgb_to_ycbcr #(.OUT_MODE(1)) dut_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
    .pix_data_in(pix), .gray_data(gray_c),
    .post_frame_vsync(pv_c), .post_frame_href(ph_c), .post_frame_clken(pc_c)
  );

  // Reference conversion straight from the BT.601 integer formulas
  function automatic logic [23:0] ref_gray(input int mode, input in_t s);
    int r, g, b, y, cb, cr;
    if (!(s.hr && s.ce)) return 24'h0;
    r  = int'(s.pix[7:0]);
    g  = int'(s.pix[15:8]);
    b  = int'(s.pix[23:16]);
    y  = (77 * r + 150 * g + 29 * b) / 256;
    cb = (128 * b - 43 * r - 85 * g + 32768) / 256;
    cr = (128 * r - 107 * g - 21 * b + 32768) / 256;
    if (mode == 0) return {y[7:0], y[7:0], y[7:0]};
    return {y[7:0], cb[7:0], cr[7:0]};
  endfunction

  function automatic logic [53:0] expect_now();
    in_t s;
    s = (hist.size() >= 4) ? hist[hist.size() - 4] : '0;
    return {ref_gray(0, s), ref_gray(1, s), s.vs, s.hr, s.ce, s.vs, s.hr, s.ce};
  endfunction

  function automatic logic [53:0] observed();
    return {gray_g, gray_c, pv_g, ph_g, pc_g, pv_c, ph_c, pc_c};
  endfunction

  task automatic tick(input logic v, input logic h, input logic c, input logic [23:0] p);
    @(negedge sys_clk);
    vs = v; hr = h; ce = c; pix = p;
    hist.push_back('{vs: v, hr: h, ce: c, pix: p});
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    vs = 0; hr = 0; ce = 0; pix = 24'h0;
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hist.delete();
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    vs = 1; hr = 1; ce = 1; pix = 24'hA5C3E7;
    repeat (4) @(negedge sys_clk);
    vectors++;
    if (observed() !== 54'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0", observed());
    end
    apply_reset();
  endtask

  task automatic test_white_black();
    apply_reset();
    tick(1, 1, 1, 24'hFFFFFF);
    tick(1, 1, 1, 24'h000000);
    tick(1, 1, 1, 24'h000000);
    vectors++;
    if (gray_g !== 24'h000000) begin
      miscompares++;
      $display("FAIL white_early: got %h expected 000000", gray_g);
    end
    tick(1, 1, 1, 24'h000000);
    vectors++;
    if (gray_g !== 24'hFFFFFF || gray_c !== 24'hFF8080) begin
      miscompares++;
      $display("FAIL white_lat3: got %h/%h expected FFFFFF/FF8080", gray_g, gray_c);
    end
    tick(1, 0, 0, 24'h000000);
    vectors++;
    if (gray_g !== 24'h000000 || gray_c !== 24'h008080) begin
      miscompares++;
      $display("FAIL black: got %h/%h expected 000000/008080", gray_g, gray_c);
    end
  endtask

  task automatic test_primaries();
    logic [23:0] tab_in [3];
    logic [23:0] tab_g  [3];
    logic [23:0] tab_c  [3];
    tab_in = '{24'h0000FF, 24'h00FF00, 24'hFF0000};
    tab_g  = '{24'h4C4C4C, 24'h959595, 24'h1C1C1C};
    tab_c  = '{24'h4C55FF, 24'h952B15, 24'h1CFF6B};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 1, tab_in[i]);
      repeat (3) tick(1, 0, 0, 24'h123456);
      vectors++;
      if (gray_g !== tab_g[i] || gray_c !== tab_c[i]) begin
        miscompares++;
        $display("FAIL primary_%0d: got %h/%h expected %h/%h", i, gray_g, gray_c, tab_g[i], tab_c[i]);
      end
    end
  endtask

  task automatic test_line();
    logic c;
    apply_reset();
    for (int i = 0; i < 660; i++) begin
      if (i < 8 || i >= 648) begin
        tick(i >= 3 && i < 655, 1'b0, 1'b1, 24'($urandom));
      end else begin
        c = !((i >= 100 && i < 104) || (i % 97 == 5));
        tick(1'b1, 1'b1, c, {8'(i * 3), 8'(i), 8'(i * 7)});
      end
      vectors++;
      if (observed() !== expect_now()) begin
        miscompares++;
        $display("FAIL line_px%0d: got %h expected %h", i, observed(), expect_now());
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 24'($urandom));
      vectors++;
      if (observed() !== expect_now()) begin
        miscompares++;
        $display("FAIL random_%0d: got %h expected %h", i, observed(), expect_now());
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (5) tick(1, 1, 1, 24'hFFFFFF);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if (observed() !== 54'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected 0", observed());
    end
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge sys_clk);
      vectors++;
      if (gray_g !== ((k == 3) ? 24'hFFFFFF : 24'h0)) begin
        miscompares++;
        $display("FAIL release_edge%0d: got %h expected %h", k, gray_g, (k == 3) ? 24'hFFFFFF : 24'h0);
      end
    end
    vs = 0; hr = 0; ce = 0; pix = 24'h0;
  endtask

  initial begin
    test_reset();
    test_white_black();
    test_primaries();
    test_line();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rgb_to_ycbcr.md
Name: rgb_to_ycbcr

Overview:
Streaming colour-space converter in the video-processing path. It sits between the camera/BMP pixel source and the frame capture/display logic. Each qualified RGB888 pixel is converted to 8-bit BT.601 Y, Cb and Cr using fixed-point arithmetic. Frame sync signals are forwarded with the same pipeline delay so that output data and timing stay aligned.

Parameters:
- OUT_MODE, default 0. Selects the output packing.
  - 0: gray, gray_data = {Y,Y,Y}.
  - 1: gray_data = {Y,Cb,Cr}.

Ports:
- sys_clk, input, 1. Pixel clock; all logic is on its rising edge.
- sys_rst_n, input, 1. Reset, asynchronous and active-low.
- per_frame_vsync, input, 1. Input frame sync (high = frame active).
- per_frame_href, input, 1. Input line-valid.
- per_frame_clken, input, 1. Input pixel qualifier.
- pix_data_in, input, 24. Input pixel in BMP byte order: [23:16]=B, [15:8]=G, [7:0]=R.
- gray_data, output, 24. Converted pixel, packed per OUT_MODE.
- post_frame_vsync, output, 1. per_frame_vsync delayed 3 cycles.
- post_frame_href, output, 1. per_frame_href delayed 3 cycles.
- post_frame_clken, output, 1. per_frame_clken delayed 3 cycles.

Behaviour:
- Reset (asynchronous, sys_rst_n low): every pipeline register and every output goes to 0 immediately. Reset is legal mid-frame; the first valid output appears 3 cycles after the first qualified input following release.
- Fixed latency is 3 clocks from a pix_data_in sample to gray_data. Sync signals pass through an identical 3-stage shift so that output sample N aligns with input sample N.
- The pipeline runs free every cycle; there is no stall and no backpressure.
- Stage 1 registers nine unsigned 8x8 products (16 bits each):
  - 77R, 150G, 29B
  - 43R, 85G, 128B
  - 128R, 107G, 21B
- Stage 2 registers three 16-bit unsigned sums:
  - Ysum = 77R + 150G + 29B
  - Cbsum = 128B − 43R − 85G + 32768
  - Crsum = 128R − 107G − 21B + 32768
  - Order the additions and subtractions, or use 17-bit intermediates, so no negative intermediate is ever formed. The final values always lie in 0..65535.
- Stage 3 truncates each sum: Y = Ysum[15:8], Cb = Cbsum[15:8], Cr = Crsum[15:8]. There is no rounding. Clamping is unnecessary because the coefficient sums are 256 and the ranges are provably within 8 bits.
- Output gating: gray_data is driven with the stage-3 result only when the delayed clken and delayed href are both 1; otherwise gray_data = 24'h000000.
- Pixels arriving with clken=0 still enter the pipeline, but their results are masked by the gating above.
- vsync is passed through only; it does not reset the datapath, and there is no frame counting.

Decomposition:
- Shared package holds:
  - the coefficient constants (Y: 77, 150, 29; Cb: 43, 85, 128; Cr: 128, 107, 21)
  - the offset 32768
  - PIPE_LAT=3
  - the OUT_MODE encodings
- One sub-module is natural: sync_delay. It is a parameterised N-stage shift register for the {vsync, href, clken} bundle, with asynchronous active-low reset to 0.

Test Plan:
- Reset then white pixel: pix_data_in=24'hFFFFFF with href=clken=1, OUT_MODE=0 → gray_data=24'hFFFFFF exactly 3 cycles later. Black 24'h000000 → 24'h000000.
- Primary colours, OUT_MODE=0 (input B,G,R bytes):
  - R=FF (24'h0000FF) → Y=76 (24'h4C4C4C)
  - G=FF (24'h00FF00) → Y=149 (0x95)
  - B=FF (24'hFF0000) → Y=28 (0x1C)
- OUT_MODE=1 colour checks:
  - R=FF → {Y,Cb,Cr} = {76, 85, 255}
  - white → {255, 128, 128}
  - black → {0, 128, 128}
- Sync alignment: drive a 640-pixel href line with a ramp; check post_frame_href/clken/vsync are the inputs delayed exactly 3 cycles, and each gray_data matches its input pixel, with no skew.
- Gating: toggle clken low mid-line → gray_data = 0 on the corresponding delayed cycles; outputs stay 0 whenever delayed href = 0.
- Asynchronous reset mid-frame: assert sys_rst_n low between clock edges → all outputs 0 immediately. After release with a constant white input → first nonzero gray_data on the 3rd rising edge.
